// File: rtl/arith_scoreboard.sv
// Latency-aware checker: replays operands through a DUT_LAT-deep line, recomputes the golden result
// and compares it with the DUT output. Optional first-mismatch capture enabled by ARITH_SCB_CAPTURE_EN.
module arith_scoreboard #(
   parameter int WIDTH   = 32,
   parameter int DUT_LAT = 2,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_valid,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_dut_os,
   input  logic             i_clear,
   output logic             o_mon_ready,
   output logic [WIDTH-1:0] o_diff,
   output logic             o_err,
   output logic [CNT_W-1:0] o_txn_cnt,
   output logic [CNT_W-1:0] o_err_cnt,
   output logic             o_cap_valid,
   output logic [WIDTH-1:0] o_cap_a,
   output logic [WIDTH-1:0] o_cap_b,
   output logic [WIDTH-1:0] o_cap_dut,
   output logic [WIDTH-1:0] o_cap_exp,
   output logic [1:0]       o_cap_op
);

   localparam int WU_W = $clog2(DUT_LAT + 1);
   localparam logic [WU_W-1:0] WU_MAX  = WU_W'(DUT_LAT);
   localparam logic [WU_W-1:0] WU_LAST = WU_W'(DUT_LAT - 1);

   logic [WU_W-1:0]  warm_q;
   logic [DUT_LAT:1] vld_pipe;
   logic [1:0]       op_pipe [DUT_LAT:1];
   logic [WIDTH-1:0] a_pipe  [DUT_LAT:1];
   logic [WIDTH-1:0] b_pipe  [DUT_LAT:1];

   logic             cmp;
   logic [WIDTH-1:0] exp_v;
   logic [WIDTH-1:0] diff_v;
   logic             mis;

   // Ready is set on the same edge the warm-up count reaches DUT_LAT, then sticks.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         warm_q      <= '0;
         o_mon_ready <= 1'b0;
      end else begin
         if (warm_q < WU_MAX) warm_q <= warm_q + 1'b1;
         if (warm_q == WU_LAST) o_mon_ready <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe <= '0;
         for (int s = 1; s <= DUT_LAT; s++) begin
            op_pipe[s] <= '0;
            a_pipe[s]  <= '0;
            b_pipe[s]  <= '0;
         end
      end else begin
         vld_pipe[1] <= i_valid & o_mon_ready;
         op_pipe[1]  <= i_op;
         a_pipe[1]   <= i_a;
         b_pipe[1]   <= i_b;
         for (int s = 2; s <= DUT_LAT; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            op_pipe[s]  <= op_pipe[s-1];
            a_pipe[s]   <= a_pipe[s-1];
            b_pipe[s]   <= b_pipe[s-1];
         end
      end
   end

   // Golden model; all results are naturally modulo 2^WIDTH.
   always_comb begin
      exp_v = '0;
      case (op_pipe[DUT_LAT])
         2'b00:   exp_v = a_pipe[DUT_LAT] + b_pipe[DUT_LAT];
         2'b01:   exp_v = a_pipe[DUT_LAT] - b_pipe[DUT_LAT];
         2'b10:   exp_v = a_pipe[DUT_LAT] ^ b_pipe[DUT_LAT];
         default: exp_v = a_pipe[DUT_LAT] * b_pipe[DUT_LAT];
      endcase
   end

   assign cmp    = vld_pipe[DUT_LAT];
   assign diff_v = exp_v ^ i_dut_os;
   assign mis    = cmp & (|diff_v);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_diff    <= '0;
         o_err     <= 1'b0;
         o_txn_cnt <= '0;
         o_err_cnt <= '0;
      end else begin
         o_diff <= cmp ? diff_v : '0;
         o_err  <= mis;
         if (i_clear) begin
            o_txn_cnt <= '0;
            o_err_cnt <= '0;
         end else begin
            if (cmp && !(&o_txn_cnt)) o_txn_cnt <= o_txn_cnt + 1'b1;
            if (mis && !(&o_err_cnt)) o_err_cnt <= o_err_cnt + 1'b1;
         end
      end
   end

`ifdef ARITH_SCB_CAPTURE_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_cap_valid <= 1'b0;
         o_cap_op    <= '0;
         o_cap_a     <= '0;
         o_cap_b     <= '0;
         o_cap_dut   <= '0;
         o_cap_exp   <= '0;
      end else if (i_clear) begin
         o_cap_valid <= 1'b0;
         o_cap_op    <= '0;
         o_cap_a     <= '0;
         o_cap_b     <= '0;
         o_cap_dut   <= '0;
         o_cap_exp   <= '0;
      end else if (mis && !o_cap_valid) begin
         o_cap_valid <= 1'b1;
         o_cap_op    <= op_pipe[DUT_LAT];
         o_cap_a     <= a_pipe[DUT_LAT];
         o_cap_b     <= b_pipe[DUT_LAT];
         o_cap_dut   <= i_dut_os;
         o_cap_exp   <= exp_v;
      end
   end
`else
   assign o_cap_valid = 1'b0;
   assign o_cap_op    = '0;
   assign o_cap_a     = '0;
   assign o_cap_b     = '0;
   assign o_cap_dut   = '0;
   assign o_cap_exp   = '0;
`endif

endmodule

// File: tb/tb_arith_scoreboard.sv
// Directed bench for arith_scoreboard (WIDTH=8, DUT_LAT=2, CNT_W=4); the bench plays the DUT and
// keeps a queue of expected compares, checked every cycle against a spec-level model.
module tb_arith_scoreboard;
   localparam int W = 8, LAT = 2, CW = 4;

   logic          clk = 1'b0, reset = 1'b1, i_valid = 1'b0, i_clear = 1'b0;
   logic [1:0]    i_op = '0;
   logic [W-1:0]  i_a = '0, i_b = '0, i_dut_os = '0;
   logic          o_mon_ready, o_err, o_cap_valid;
   logic [W-1:0]  o_diff, o_cap_a, o_cap_b, o_cap_dut, o_cap_exp;
   logic [CW-1:0] o_txn_cnt, o_err_cnt;
   logic [1:0]    o_cap_op;

   arith_scoreboard #(.WIDTH(W), .DUT_LAT(LAT), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .i_valid(i_valid), .i_op(i_op), .i_a(i_a), .i_b(i_b),
      .i_dut_os(i_dut_os), .i_clear(i_clear), .o_mon_ready(o_mon_ready), .o_diff(o_diff),
      .o_err(o_err), .o_txn_cnt(o_txn_cnt), .o_err_cnt(o_err_cnt), .o_cap_valid(o_cap_valid),
      .o_cap_a(o_cap_a), .o_cap_b(o_cap_b), .o_cap_dut(o_cap_dut), .o_cap_exp(o_cap_exp),
      .o_cap_op(o_cap_op)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         due;
      logic [1:0] op;
      logic [W-1:0] a, b, dut, exp;
   } exp_t;

   exp_t          sb[$];
   logic [W-1:0]  dut_sched[int];
   int            n_chk = 0, n_fail = 0, cyc = 0, rel = 1 << 30;
   logic [CW-1:0] m_txn = '0, m_err = '0;
   logic          m_capv = 1'b0, clr_q = 1'b0;
   exp_t          m_cap = '{default: '0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] gold(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      case (op)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a ^ b;
         default: return p[W-1:0];
      endcase
   endfunction

   task automatic model_zero();
      m_txn = '0; m_err = '0; m_capv = 1'b0; m_cap = '{default: '0};
   endtask

   task automatic expect_zero(input string tag);
      chk({tag, "_ready"}, o_mon_ready, 0);
      chk({tag, "_diff"}, o_diff, 0);
      chk({tag, "_err"}, o_err, 0);
      chk({tag, "_txn"}, o_txn_cnt, 0);
      chk({tag, "_errcnt"}, o_err_cnt, 0);
      chk({tag, "_capv"}, o_cap_valid, 0);
      chk({tag, "_cap"}, {o_cap_op, o_cap_a, o_cap_b, o_cap_dut, o_cap_exp}, 0);
   endtask

   // Drive one transaction in the current cycle; corrupt != 0 makes the played DUT answer wrong.
   task automatic drive(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] corrupt);
      logic [W-1:0] e;
      i_valid = 1'b1; i_op = op; i_a = a; i_b = b;
      if (cyc >= rel + LAT) begin
         e = gold(op, a, b);
         dut_sched[cyc + LAT] = e ^ corrupt;
         sb.push_back('{due: cyc + LAT + 1, op: op, a: a, b: b, dut: e ^ corrupt, exp: e});
      end
   endtask

   task automatic check_cycle();
      exp_t e;
      logic [W-1:0] ed;
      logic ee;
      ed = '0; ee = 1'b0;
      if (clr_q) model_zero();
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e  = sb.pop_front();
         ed = e.exp ^ e.dut;
         ee = |ed;
         if (!clr_q) begin
            if (m_txn != '1) m_txn++;
            if (ee) begin
               if (m_err != '1) m_err++;
               if (!m_capv) begin m_capv = 1'b1; m_cap = e; end
            end
         end
      end
      chk("ready", o_mon_ready, cyc >= rel + LAT);
      chk("diff", o_diff, ed);
      chk("err", o_err, ee);
      chk("txn_cnt", o_txn_cnt, m_txn);
      chk("err_cnt", o_err_cnt, m_err);
`ifdef ARITH_SCB_CAPTURE_EN
      chk("cap_valid", o_cap_valid, m_capv);
      chk("cap_op", o_cap_op, m_cap.op);
      chk("cap_a", o_cap_a, m_cap.a);
      chk("cap_b", o_cap_b, m_cap.b);
      chk("cap_dut", o_cap_dut, m_cap.dut);
      chk("cap_exp", o_cap_exp, m_cap.exp);
`else
      chk("cap_valid", o_cap_valid, 0);
      chk("cap_all", {o_cap_op, o_cap_a, o_cap_b, o_cap_dut, o_cap_exp}, 0);
`endif
   endtask

   task automatic step();
      clr_q = i_clear;
      @(posedge clk); #1;
      cyc++;
      i_valid = 1'b0; i_clear = 1'b0;
      i_dut_os = dut_sched.exists(cyc) ? dut_sched[cyc] : W'($urandom);
      check_cycle();
   endtask

   initial begin
      // Reset state and warm-up with i_valid held high from release.
      #1; expect_zero("rst");
      step(); step();
      reset = 1'b0; rel = cyc;
      for (int i = 0; i < 5; i++) begin
         drive(2'd0, W'($urandom), W'($urandom), '0);
         step();
      end
      for (int i = 0; i < 4; i++) step();
      chk("warm_txn", o_txn_cnt, 3);

      // add 0xF0+0x20 wraps to 0x10, DUT agrees
      drive(2'd0, 8'hF0, 8'h20, 8'h00);
      for (int i = 0; i < 4; i++) step();

      // mul 0x13*0x11 = 0x43, DUT returns 0x42; then a second mismatch must not move the capture
      drive(2'd3, 8'h13, 8'h11, 8'h01);
      for (int i = 0; i < 4; i++) step();
      drive(2'd2, 8'h5A, 8'hC3, 8'h80);
      for (int i = 0; i < 4; i++) step();

      // 20 back-to-back mismatching subs: counters saturate at 0xF
      for (int i = 0; i < 20; i++) begin
         drive(2'd1, W'($urandom), W'($urandom), W'($urandom_range(1, 255)));
         step();
      end
      for (int i = 0; i < 4; i++) step();
      chk("sat_txn", o_txn_cnt, 4'hF);
      chk("sat_err", o_err_cnt, 4'hF);

      // clear coincident with a mismatch compare, then a fresh capture
      drive(2'd0, 8'h11, 8'h22, 8'h04);
      step(); step();
      i_clear = 1'b1;
      step();
      step();
      drive(2'd1, 8'h07, 8'h09, 8'h10);
      for (int i = 0; i < 4; i++) step();

      // reset with two transactions in flight
      drive(2'd0, 8'h01, 8'h02, 8'h01); step();
      drive(2'd2, 8'h0F, 8'hF0, 8'h02); step();
      reset = 1'b1;
      #1; expect_zero("midrst");
      model_zero(); sb.delete(); dut_sched.delete(); rel = 1 << 30;
      step(); step();
      reset = 1'b0; rel = cyc;
      for (int i = 0; i < 5; i++) step();
      drive(2'd3, 8'h0B, 8'h0D, 8'h00);
      for (int i = 0; i < 4; i++) step();
      chk("post_rst_txn", o_txn_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
